// File: rtl/sound_mixer.sv
// Time-multiplexed audio mixer: per-channel volume and pan on one multiplier, saturated signed 16-bit L/R.
// Optional DC blocker after saturation when SOUND_MIXER_DCBLOCK_EN is defined.
module sound_mixer #(
  parameter int NCH  = 4,
  parameter int VOLW = 4
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   i_ce_sample,
  input  logic [NCH*8-1:0]       i_sample,
  input  logic [NCH*VOLW-1:0]    i_vol,
  input  logic [NCH*2-1:0]       i_pan,
  output logic signed [15:0]     o_audio_l,
  output logic signed [15:0]     o_audio_r,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic [1:0]             o_clip,
  output logic                   o_overrun
);

  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACCW  = 9 + VOLW + $clog2(NCH) + 1;
  localparam int SHIFT = 8 - VOLW;  // VOLW is expected to be at most 8

`ifdef SOUND_MIXER_DCBLOCK_EN
  typedef enum logic [1:0] {IDLE, ACC, SAT, FILT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;
`endif

  state_t                 state_q, state_d;
  logic [CHW-1:0]         chan_q;
  logic [NCH*8-1:0]       smp_p0;
  logic [NCH*VOLW-1:0]    vol_p0;
  logic [NCH*2-1:0]       pan_p0;
  logic signed [ACCW-1:0] acc_l_p1, acc_r_p1;

  int                     ch;
  logic [7:0]             smp_c;
  logic [VOLW-1:0]        vol_c;
  logic [1:0]             pan_c;
  logic signed [8:0]      s_c;
  logic signed [ACCW-1:0] prod_c;
  logic [16:0]            sat_l_c, sat_r_c;

  function automatic logic signed [31:0] scale(input logic signed [ACCW-1:0] a);
    logic signed [31:0] ext;
    ext = {{(32-ACCW){a[ACCW-1]}}, a};
    return ext <<< SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [16:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)        return {1'b1, 16'h7fff};
    else if (v < -32'sd32768)  return {1'b1, 16'h8000};
    else                       return {1'b0, v[15:0]};
  endfunction

  function automatic logic [24:0] sat24(input logic signed [31:0] v);
    if (v > 32'sd8388607)        return {1'b1, 24'h7fffff};
    else if (v < -32'sd8388608)  return {1'b1, 24'h800000};
    else                         return {1'b0, v[23:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_ce_sample) state_d = ACC;
      ACC:  if (chan_q == CHW'(NCH-1)) state_d = SAT;
`ifdef SOUND_MIXER_DCBLOCK_EN
      SAT:  state_d = FILT;
      FILT: state_d = IDLE;
`else
      SAT:  state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Offset-binary to two's complement is an MSB flip; product width covers -128*(2^VOLW-1).
  always_comb begin
    ch     = int'(chan_q);
    smp_c  = smp_p0[8*ch +: 8];
    vol_c  = vol_p0[VOLW*ch +: VOLW];
    pan_c  = pan_p0[2*ch +: 2];
    s_c    = {~smp_c[7], ~smp_c[7], smp_c[6:0]};
    prod_c = {{(ACCW-9){s_c[8]}}, s_c} * {{(ACCW-VOLW){1'b0}}, vol_c};
  end

  assign sat_l_c = sat16(scale(acc_l_p1));
  assign sat_r_c = sat16(scale(acc_r_p1));
  assign o_busy  = (state_q != IDLE);

`ifdef SOUND_MIXER_DCBLOCK_EN
  logic signed [15:0] x_l_p2, x_r_p2, xd_l, xd_r;
  logic signed [23:0] y_l, y_r;
  logic [24:0]        yn_l_c, yn_r_c;

  // y is Q16.8: x scaled by 256, leak of y/256 per sample.
  function automatic logic signed [31:0] dc_next(input logic signed [15:0] x, input logic signed [15:0] xp,
                                                 input logic signed [23:0] y);
    logic signed [31:0] xw, xpw, yw;
    xw  = {{8{x[15]}}, x, 8'h00};
    xpw = {{8{xp[15]}}, xp, 8'h00};
    yw  = {{8{y[23]}}, y};
    return xw - xpw + yw - (yw >>> 8);
  endfunction

  assign yn_l_c = sat24(dc_next(x_l_p2, xd_l, y_l));
  assign yn_r_c = sat24(dc_next(x_r_p2, xd_r, y_r));
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      chan_q    <= '0;
      acc_l_p1  <= '0;
      acc_r_p1  <= '0;
      o_audio_l <= '0;
      o_audio_r <= '0;
      o_valid   <= 1'b0;
      o_clip    <= 2'b00;
      o_overrun <= 1'b0;
`ifdef SOUND_MIXER_DCBLOCK_EN
      xd_l      <= '0;
      xd_r      <= '0;
      y_l       <= '0;
      y_r       <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      if (i_ce_sample && state_q != IDLE) o_overrun <= 1'b1;
      case (state_q)
        // p0: snapshot inputs so later changes cannot disturb this mix
        IDLE: if (i_ce_sample) begin
          smp_p0   <= i_sample;
          vol_p0   <= i_vol;
          pan_p0   <= i_pan;
          acc_l_p1 <= '0;
          acc_r_p1 <= '0;
          chan_q   <= '0;
        end
        // p1: one channel per cycle into both accumulators
        ACC: begin
          acc_l_p1 <= acc_l_p1 + (pan_c[0] ? prod_c : '0);
          acc_r_p1 <= acc_r_p1 + (pan_c[1] ? prod_c : '0);
          chan_q   <= chan_q + CHW'(1);
        end
        // p2: scale to 16 bits and clamp
        SAT: begin
          o_clip <= o_clip | {sat_r_c[16], sat_l_c[16]};
`ifdef SOUND_MIXER_DCBLOCK_EN
          x_l_p2 <= sat_l_c[15:0];
          x_r_p2 <= sat_r_c[15:0];
`else
          o_audio_l <= sat_l_c[15:0];
          o_audio_r <= sat_r_c[15:0];
          o_valid   <= 1'b1;
`endif
        end
`ifdef SOUND_MIXER_DCBLOCK_EN
        // p3: DC blocker, output is integer part of y
        FILT: begin
          o_audio_l <= yn_l_c[23:8];
          o_audio_r <= yn_r_c[23:8];
          o_clip    <= o_clip | {yn_r_c[24], yn_l_c[24]};
          y_l       <= yn_l_c[23:0];
          y_r       <= yn_r_c[23:0];
          xd_l      <= x_l_p2;
          xd_r      <= x_r_p2;
          o_valid   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sound_mixer.md
Name: sound_mixer

Overview:
Multi-channel audio mixer sitting directly downstream of the sample players (wav_player, dkongjr_wav_sound, zaxxon_discrete_sound). It consumes their 8-bit unsigned sample outputs and produces the signed 16-bit AUDIO_L/AUDIO_R words, replacing ad-hoc concatenation/addition. It applies per-channel volume and pan, accumulates channels time-multiplexed on one multiplier, and saturates the result. Output is signed, so the top level drives AUDIO_S=1.

Parameters:
NCH, 4, number of input channels (1..8)
VOLW, 4, per-channel volume width; gain = vol/2^VOLW, vol=15 is near unity

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
i_ce_sample  in  1  one-cycle output-sample strobe (e.g. 48 kHz)
i_sample  in  NCH*8  unsigned samples, channel k at [8k+7:8k], 128 = silence
i_vol  in  NCH*VOLW  per-channel volume, channel k at [VOLW*k+VOLW-1:VOLW*k]
i_pan  in  NCH*2  channel k: bit 2k = route left, bit 2k+1 = route right
o_audio_l  out  16  signed mixed left
o_audio_r  out  16  signed mixed right
o_valid  out  1  one-cycle pulse, new o_audio_l/o_audio_r
o_busy  out  1  high while not IDLE
o_clip  out  2  sticky saturation flags {right,left}
o_overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset: o_audio_l=o_audio_r=0, o_valid=0, o_busy=0, o_clip=0, o_overrun=0, accumulators=0, state IDLE. Reset mid-mix aborts with no o_valid.
- FSM: IDLE -> ACC -> SAT -> IDLE.
- IDLE: on i_ce_sample, snapshot i_sample/i_vol/i_pan into registers, clear acc_l/acc_r, chan=0, go ACC. Input changes after the strobe cycle do not affect this mix.
- ACC: one channel per cycle, chan 0..NCH-1. s = sample-128 (signed 9b, -128..127). p = s*vol (signed, 9+VOLW bits). acc_l += p if pan[2k]; acc_r += p if pan[2k+1]. Accumulator width 9+VOLW+ceil(log2 NCH)+1, no internal overflow. After chan NCH-1, go SAT.
- SAT: v = acc <<< (16-9-VOLW+... fixed shift 4 for VOLW=4, i.e. shift = 8-VOLW). Clamp to [-32768, 32767]. Clamp sets the matching o_clip bit. Outputs are registered. o_valid=1 for exactly one cycle. Return to IDLE.
- Latency: strobe in cycle 0 -> o_valid in cycle NCH+2 (6 for NCH=4). Outputs hold between pulses.
- Strobe while o_busy: ignored, mix in progress is unaffected, o_overrun set. Strobe on the same cycle the FSM returns to IDLE (the o_valid cycle) is accepted.
- Max strobe rate: one per NCH+2 cycles.
- vol=0 or pan=00 contributes exactly 0. Sample 128 contributes exactly 0 at any volume.

Optional Feature:
SOUND_MIXER_DCBLOCK_EN
- Defined: adds state FILT after SAT, with per-side DC blocker y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1]>>>8).
  - x is the saturated value; y is kept in 24-bit signed with 8 fractional bits.
  - The output is y re-saturated to 16 bits; re-saturation also sets o_clip.
  - Latency becomes NCH+3.
  - x[n-1] and y[n-1] reset to 0.
- Undefined: no FILT state, latency NCH+2.

Test Plan:
1. NCH=4, ch0 sample=255 vol=15 pan=01, others vol=0; strobe -> cycle 6 o_valid, o_audio_l=1905<<4=30480, o_audio_r=0, o_clip=00.
2. All 4 channels sample=255 vol=15 pan=11 -> o_audio_l=o_audio_r=32767, o_clip=11. Then all sample=0 -> both -32768.
3. ch0=0 vol=15 pan=10 plus ch1=255 vol=15 pan=10 -> o_audio_r=(-1920+1905)<<4=-240, o_audio_l=0.
4. Strobe, then strobe again 2 cycles later -> single o_valid at cycle 6, o_overrun=1. Strobe at cycle 6 is accepted (o_valid at cycle 12).
5. Reset asserted at cycle 3 of a mix -> no o_valid. Outputs and flags return to 0. Next strobe mixes correctly.
6. DCBLOCK_EN: constant ch0=255 vol=15 pan=01 for 2000 strobes -> first output 30480, |o_audio_l| < 64 by strobe 2000.
